// File: rtl/data_memory_lsu_if.sv
// Load/store bus between the datapath (master) and data_memory_lsu (slave).
// DMEM_ERR_STICKY_EN adds the sticky fault-capture signals.
interface data_memory_lsu_if;
  logic [31:0] Address;
  logic [31:0] WriteData;
  logic        MemWrite;
  logic        MemRead;
  logic [1:0]  Size;
  logic        Unsigned;
  logic [31:0] ReadData;
  logic        ReadValid;
  logic        AddrError;
`ifdef DMEM_ERR_STICKY_EN
  logic        ErrClear;
  logic        ErrSticky;
  logic [31:0] ErrAddr;

  modport master (
    output Address, WriteData, MemWrite, MemRead, Size, Unsigned, ErrClear,
    input  ReadData, ReadValid, AddrError, ErrSticky, ErrAddr
  );
  modport slave (
    input  Address, WriteData, MemWrite, MemRead, Size, Unsigned, ErrClear,
    output ReadData, ReadValid, AddrError, ErrSticky, ErrAddr
  );
`else
  modport master (
    output Address, WriteData, MemWrite, MemRead, Size, Unsigned,
    input  ReadData, ReadValid, AddrError
  );
  modport slave (
    input  Address, WriteData, MemWrite, MemRead, Size, Unsigned,
    output ReadData, ReadValid, AddrError
  );
`endif
endinterface

// File: rtl/data_memory_lsu.sv
// Byte/half/word data memory with a READ_LATENCY-deep registered load pipeline and fault flag.
// Define DMEM_ERR_STICKY_EN to add ErrClear/ErrSticky/ErrAddr first-fault capture.
module data_memory_lsu #(
  parameter int          DATA_WIDTH   = 32,
  parameter int          MEMORY_DEPTH = 2048,
  parameter logic [31:0] BASE_ADDR    = 32'h10010000,
  parameter int          READ_LATENCY = 1
) (
  input logic              clk,
  input logic              reset,
  data_memory_lsu_if.slave bus
);
  localparam int AW = (MEMORY_DEPTH > 1) ? $clog2(MEMORY_DEPTH) : 1;

  logic [29:0]           wordIdx;
  logic [AW-1:0]         ramIdx;
  logic [1:0]            lane;
  logic                  outOfRange;
  logic                  misaligned;
  logic                  reqFault;
  logic                  loadReq;
  logic                  storeReq;
  logic                  storeOk;
  logic [3:0]            byteEn;
  logic [DATA_WIDTH-1:0] wrData;
  logic [DATA_WIDTH-1:0] rdWord;
  logic [DATA_WIDTH-1:0] extData;
  logic [DATA_WIDTH-1:0] dataOut;
  logic [7:0]            byteVal;
  logic [15:0]           halfVal;
  logic                  readValid;

  logic [1:0]              sizeS1_reg;
  logic                    unsS1_reg;
  logic [1:0]              laneS1_reg;
  logic [READ_LATENCY-1:0] validPipe_reg;
  logic [READ_LATENCY-1:0] errPipe_reg;
  logic                    storeErr_reg;

  // BASE_ADDR is word aligned, so the word index is the difference of the word fields.
  assign lane       = bus.Address[1:0];
  assign wordIdx    = bus.Address[31:2] - BASE_ADDR[31:2];
  assign ramIdx     = wordIdx[AW-1:0];
  assign outOfRange = (bus.Address < BASE_ADDR) || (wordIdx >= 30'(MEMORY_DEPTH));

  always_comb begin
    misaligned = 1'b0;
    byteEn     = 4'b0000;
    wrData     = bus.WriteData;
    case (bus.Size)
      2'b00: begin
        byteEn = 4'b0001 << lane;
        wrData = {4{bus.WriteData[7:0]}};
      end
      2'b01: begin
        misaligned = lane[0];
        byteEn     = lane[1] ? 4'b1100 : 4'b0011;
        wrData     = {2{bus.WriteData[15:0]}};
      end
      2'b10: begin
        misaligned = (lane != 2'b00);
        byteEn     = 4'b1111;
      end
      default: misaligned = 1'b1;
    endcase
  end

  // A simultaneous read+write is answered on the load path so the requester still sees ReadValid.
  assign loadReq  = bus.MemRead;
  assign storeReq = bus.MemWrite & ~bus.MemRead;
  assign reqFault = (bus.MemRead | bus.MemWrite) &
                    (outOfRange | misaligned | (bus.MemRead & bus.MemWrite));
  assign storeOk  = storeReq & ~reqFault;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : gLane
      logic [7:0] laneMem [MEMORY_DEPTH];
      logic [7:0] laneQ_reg;

      always_ff @(posedge clk) begin
        if (storeOk && byteEn[gi]) laneMem[ramIdx] <= wrData[8*gi +: 8];
        if (loadReq) laneQ_reg <= laneMem[ramIdx];
      end

      assign rdWord[8*gi +: 8] = laneQ_reg;
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      validPipe_reg <= '0;
      errPipe_reg   <= '0;
      storeErr_reg  <= 1'b0;
      sizeS1_reg    <= 2'b00;
      unsS1_reg     <= 1'b0;
      laneS1_reg    <= 2'b00;
    end else begin
      validPipe_reg[0] <= loadReq;
      errPipe_reg[0]   <= loadReq & reqFault;
      for (int i = 1; i < READ_LATENCY; i++) begin
        validPipe_reg[i] <= validPipe_reg[i-1];
        errPipe_reg[i]   <= errPipe_reg[i-1];
      end
      storeErr_reg <= storeReq & reqFault;
      if (loadReq) begin
        sizeS1_reg <= bus.Size;
        unsS1_reg  <= bus.Unsigned;
        laneS1_reg <= lane;
      end
    end
  end

  // Stage 1: lane extract and extension straight off the RAM output register.
  always_comb begin
    byteVal = rdWord[7:0];
    case (laneS1_reg)
      2'b01:   byteVal = rdWord[15:8];
      2'b10:   byteVal = rdWord[23:16];
      2'b11:   byteVal = rdWord[31:24];
      default: byteVal = rdWord[7:0];
    endcase
    halfVal = laneS1_reg[1] ? rdWord[31:16] : rdWord[15:0];
    extData = '0;
    if (!errPipe_reg[0]) begin
      case (sizeS1_reg)
        2'b00:   extData = unsS1_reg ? {24'h000000, byteVal} : {{24{byteVal[7]}}, byteVal};
        2'b01:   extData = unsS1_reg ? {16'h0000, halfVal} : {{16{halfVal[15]}}, halfVal};
        default: extData = rdWord;
      endcase
    end
  end

  generate
    if (READ_LATENCY == 1) begin : gNoDelay
      assign dataOut = extData;
    end else begin : gDelay
      logic [DATA_WIDTH-1:0] dataDly_reg [READ_LATENCY-1];

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          for (int i = 0; i < READ_LATENCY - 1; i++) dataDly_reg[i] <= '0;
        end else begin
          dataDly_reg[0] <= extData;
          for (int i = 1; i < READ_LATENCY - 1; i++) dataDly_reg[i] <= dataDly_reg[i-1];
        end
      end

      assign dataOut = dataDly_reg[READ_LATENCY-2];
    end
  endgenerate

  assign readValid     = validPipe_reg[READ_LATENCY-1];
  assign bus.ReadValid = readValid;
  assign bus.ReadData  = readValid ? dataOut : '0;
  assign bus.AddrError = errPipe_reg[READ_LATENCY-1] | storeErr_reg;

`ifdef DMEM_ERR_STICKY_EN
  logic        errSticky_reg;
  logic [31:0] errAddr_reg;

  // A fault in the same cycle as ErrClear re-arms with the new address.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      errSticky_reg <= 1'b0;
      errAddr_reg   <= 32'h0;
    end else if (reqFault && (!errSticky_reg || bus.ErrClear)) begin
      errSticky_reg <= 1'b1;
      errAddr_reg   <= bus.Address;
    end else if (bus.ErrClear) begin
      errSticky_reg <= 1'b0;
      errAddr_reg   <= 32'h0;
    end
  end

  assign bus.ErrSticky = errSticky_reg;
  assign bus.ErrAddr   = errAddr_reg;
`endif
endmodule

// File: tb/tb_data_memory_lsu.sv
// Random + directed bench for data_memory_lsu at READ_LATENCY 1 and 3, driven with identical
// stimulus and compared every cycle against a byte-level memory model.
module tb_data_memory_lsu;
  localparam logic [31:0] BASE  = 32'h10010000;
  localparam int          DEPTH = 2048;
  localparam int          NHIST = 4096;

  typedef struct packed {
    logic        ld;
    logic [31:0] data;
    logic        lerr;
    logic        serr;
    logic        sticky;
    logic [31:0] eaddr;
  } resp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic rstLevel = 1'b0;
  always #5 clk = ~clk;

  data_memory_lsu_if bus1 ();
  data_memory_lsu_if bus3 ();

  data_memory_lsu #(.DATA_WIDTH(32), .MEMORY_DEPTH(DEPTH), .BASE_ADDR(BASE), .READ_LATENCY(1))
    dut1 (.clk(clk), .reset(reset), .bus(bus1.slave));
  data_memory_lsu #(.DATA_WIDTH(32), .MEMORY_DEPTH(DEPTH), .BASE_ADDR(BASE), .READ_LATENCY(3))
    dut3 (.clk(clk), .reset(reset), .bus(bus3.slave));

  resp_t       hist [NHIST];
  int          k = -1;
  int          checks = 0;
  int          errors = 0;
  bit          started = 1'b0;
  logic [7:0]  mm [logic [31:0]];
  logic        mSticky = 1'b0;
  logic [31:0] mErrAddr = 32'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h, expected %h", name, k, act, exp);
    end
  endtask

  function automatic resp_t at(input int i);
    resp_t r;
    r = '0;
    if (i >= 0) r = hist[i];
    return r;
  endfunction

  function automatic logic [31:0] modelLoad(input logic [31:0] a, input logic [1:0] sz,
                                            input logic us);
    logic [31:0] w;
    logic [15:0] h;
    case (sz)
      2'b00: begin
        w = {24'h0, mm[a]};
        if (!us && mm[a][7]) w = w | 32'hFFFFFF00;
      end
      2'b01: begin
        h = {mm[a+1], mm[a]};
        w = us ? {16'h0, h} : {{16{h[15]}}, h};
      end
      default: w = {mm[a+3], mm[a+2], mm[a+1], mm[a]};
    endcase
    return w;
  endfunction

  task automatic modelStore(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] wd);
    int nb;
    nb = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    for (int i = 0; i < nb; i++) mm[a + i] = wd[8*i +: 8];
  endtask

  task automatic req(input logic rd, input logic wr, input logic [1:0] sz, input logic us,
                     input logic [31:0] addr, input logic [31:0] wd, input logic clr);
    resp_t r;
    logic  fault;
    int    nb;
    @(posedge clk);
    #1;
    reset = rstLevel;
    bus1.MemRead = rd;  bus1.MemWrite = wr;  bus1.Size = sz;  bus1.Unsigned = us;
    bus1.Address = addr; bus1.WriteData = wd;
    bus3.MemRead = rd;  bus3.MemWrite = wr;  bus3.Size = sz;  bus3.Unsigned = us;
    bus3.Address = addr; bus3.WriteData = wd;
`ifdef DMEM_ERR_STICKY_EN
    bus1.ErrClear = clr;
    bus3.ErrClear = clr;
`endif
    k++;
    r = '0;
    fault = 1'b0;
    if (!rstLevel) begin
      mSticky  = 1'b0;
      mErrAddr = 32'h0;
    end else begin
      nb = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
      fault = (rd || wr) && (addr < BASE || ((addr - BASE) >> 2) >= DEPTH || sz == 2'b11 ||
                             (addr % nb) != 0 || (rd && wr));
      if (rd) begin
        r.ld   = 1'b1;
        r.lerr = fault;
        if (!fault) r.data = modelLoad(addr, sz, us);
      end else if (wr) begin
        r.serr = fault;
        if (!fault) modelStore(addr, sz, wd);
      end
      if (fault && (!mSticky || clr)) begin
        mSticky  = 1'b1;
        mErrAddr = addr;
      end else if (clr) begin
        mSticky  = 1'b0;
        mErrAddr = 32'h0;
      end
    end
    r.sticky = mSticky;
    r.eaddr  = mErrAddr;
    hist[k]  = r;
    started  = 1'b1;
    $display("txn %0d rst_n=%0b rd=%0b wr=%0b size=%0d uns=%0b addr=%h wdata=%h clr=%0b -> fault=%0b load_data=%h",
             k, rstLevel, rd, wr, sz, us, addr, wd, clr, fault, r.data);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) req(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 1'b0);
  endtask

  function automatic logic [31:0] randAddr();
    int unsigned sel;
    logic [31:0] a;
    sel = $urandom_range(0, 9);
    case (sel)
      0: a = BASE - $urandom_range(1, 8);
      1: a = BASE + DEPTH * 4 + $urandom_range(0, 7);
      2: begin
        a = $urandom;
        if (a >= BASE && a < BASE + DEPTH * 4) a = BASE - 32'd16;
      end
      3, 4, 5: a = BASE + (DEPTH - 8 + $urandom_range(0, 7)) * 4 + $urandom_range(0, 3);
      default: a = BASE + $urandom_range(0, 15) * 4 + $urandom_range(0, 3);
    endcase
    return a;
  endfunction

  // Outputs are sampled mid-cycle; request k is the one currently on the bus.
  always @(negedge clk) begin
    if (started) begin
      resp_t e1, e3, es;
      e1 = at(k - 1);
      e3 = at(k - 3);
      es = at(k - 1);
      check("ReadValid_lat1", {31'h0, bus1.ReadValid}, {31'h0, e1.ld});
      check("ReadData_lat1", bus1.ReadData, e1.data);
      check("AddrError_lat1", {31'h0, bus1.AddrError}, {31'h0, e1.lerr | es.serr});
      check("ReadValid_lat3", {31'h0, bus3.ReadValid}, {31'h0, e3.ld});
      check("ReadData_lat3", bus3.ReadData, e3.data);
      check("AddrError_lat3", {31'h0, bus3.AddrError}, {31'h0, e3.lerr | es.serr});
`ifdef DMEM_ERR_STICKY_EN
      check("ErrSticky_lat1", {31'h0, bus1.ErrSticky}, {31'h0, es.sticky});
      check("ErrAddr_lat1", bus1.ErrAddr, es.eaddr);
      check("ErrSticky_lat3", {31'h0, bus3.ErrSticky}, {31'h0, es.sticky});
      check("ErrAddr_lat3", bus3.ErrAddr, es.eaddr);
`endif
    end
  end

  initial begin
    bus1.MemRead = 1'b0; bus1.MemWrite = 1'b0; bus1.Size = 2'b00; bus1.Unsigned = 1'b0;
    bus1.Address = 32'h0; bus1.WriteData = 32'h0;
    bus3.MemRead = 1'b0; bus3.MemWrite = 1'b0; bus3.Size = 2'b00; bus3.Unsigned = 1'b0;
    bus3.Address = 32'h0; bus3.WriteData = 32'h0;
`ifdef DMEM_ERR_STICKY_EN
    bus1.ErrClear = 1'b0;
    bus3.ErrClear = 1'b0;
`endif
    idle(3);
    rstLevel = 1'b1;
    idle(2);

    // Directed sequence with hand-computed expectations.
    req(1'b0, 1'b1, 2'b10, 1'b0, BASE + 4, 32'hDEADBEEF, 1'b0);
    req(1'b1, 1'b0, 2'b10, 1'b0, BASE + 4, 32'h0, 1'b0);
    check("lit_lw_deadbeef", hist[k].data, 32'hDEADBEEF);
    req(1'b0, 1'b1, 2'b00, 1'b0, BASE + 5, 32'h00000080, 1'b0);
    req(1'b1, 1'b0, 2'b10, 1'b0, BASE + 4, 32'h0, 1'b0);
    check("lit_lw_after_sb", hist[k].data, 32'hDEAD80EF);
    req(1'b1, 1'b0, 2'b00, 1'b0, BASE + 5, 32'h0, 1'b0);
    check("lit_lb", hist[k].data, 32'hFFFFFF80);
    req(1'b1, 1'b0, 2'b00, 1'b1, BASE + 5, 32'h0, 1'b0);
    check("lit_lbu", hist[k].data, 32'h00000080);
    req(1'b0, 1'b1, 2'b01, 1'b0, BASE + 6, 32'h00008001, 1'b0);
    req(1'b1, 1'b0, 2'b01, 1'b0, BASE + 6, 32'h0, 1'b0);
    check("lit_lh", hist[k].data, 32'hFFFF8001);
    req(1'b1, 1'b0, 2'b01, 1'b1, BASE + 6, 32'h0, 1'b0);
    check("lit_lhu", hist[k].data, 32'h00008001);
    req(1'b1, 1'b0, 2'b10, 1'b0, BASE + 4, 32'h0, 1'b0);
    check("lit_lw_after_sh", hist[k].data, 32'h800180EF);
    req(1'b1, 1'b0, 2'b10, 1'b0, BASE + 2, 32'h0, 1'b0);
    check("lit_lw_misaligned_err", {31'h0, hist[k].lerr}, 32'h1);
    check("lit_lw_misaligned_data", hist[k].data, 32'h0);
    req(1'b0, 1'b1, 2'b10, 1'b0, 32'h1000FFFC, 32'h12345678, 1'b0);
    check("lit_sw_below_base_err", {31'h0, hist[k].serr}, 32'h1);
    req(1'b1, 1'b0, 2'b10, 1'b0, 32'h10012000, 32'h0, 1'b0);
    check("lit_lw_past_depth_err", {31'h0, hist[k].lerr}, 32'h1);
    req(1'b1, 1'b0, 2'b10, 1'b0, BASE + 4, 32'h0, 1'b0);
    check("lit_lw_unchanged", hist[k].data, 32'h800180EF);

`ifdef DMEM_ERR_STICKY_EN
    req(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 1'b1);
    req(1'b1, 1'b0, 2'b10, 1'b0, 32'h10010001, 32'h0, 1'b0);
    req(1'b1, 1'b0, 2'b10, 1'b0, 32'h10010003, 32'h0, 1'b0);
    check("lit_erraddr_first", mErrAddr, 32'h10010001);
    req(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 1'b1);
    check("lit_sticky_cleared", {31'h0, mSticky}, 32'h0);
    idle(2);
`endif

    // Seed the regions the random phase touches so every load reads known bytes.
    for (int w = 0; w < 16; w++) req(1'b0, 1'b1, 2'b10, 1'b0, BASE + w * 4, $urandom, 1'b0);
    for (int w = DEPTH - 8; w < DEPTH; w++)
      req(1'b0, 1'b1, 2'b10, 1'b0, BASE + w * 4, $urandom, 1'b0);

    for (int n = 0; n < 1500; n++) begin
      int unsigned op, szr;
      logic rd, wr, clr;
      logic [1:0] sz;
      op  = $urandom_range(0, 19);
      szr = $urandom_range(0, 9);
      sz  = (szr < 3) ? 2'b00 : (szr < 6) ? 2'b01 : (szr < 9) ? 2'b10 : 2'b11;
      rd  = (op >= 3 && op <= 10) || op == 19;
      wr  = op >= 11;
      clr = ($urandom_range(0, 7) == 0);
      req(rd, wr, sz, 1'($urandom_range(0, 1)), randAddr(), $urandom, clr);
    end

    // Three back-to-back loads, then reset asserted before the third is accepted.
    req(1'b1, 1'b0, 2'b10, 1'b0, BASE + 0, 32'h0, 1'b0);
    req(1'b1, 1'b0, 2'b10, 1'b0, BASE + 4, 32'h0, 1'b0);
    req(1'b1, 1'b0, 2'b10, 1'b0, BASE + 8, 32'h0, 1'b0);
    #2;
    reset    = 1'b0;
    rstLevel = 1'b0;
    for (int i = k - 4; i <= k; i++) if (i >= 0) hist[i] = '0;
    mSticky  = 1'b0;
    mErrAddr = 32'h0;
    idle(3);
    rstLevel = 1'b1;

    for (int n = 0; n < 200; n++) begin
      int unsigned op;
      op = $urandom_range(0, 19);
      req((op >= 3 && op <= 10) || op == 19, op >= 11, 2'($urandom_range(0, 2)),
          1'($urandom_range(0, 1)), randAddr(), $urandom, ($urandom_range(0, 7) == 0));
    end
    idle(6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
